// File: rtl/scan_display_ctrl.sv
// 4-digit multiplexed 7-segment scan controller with a frame-synchronous
// double-buffered BCD value, dead time between digits and leading-zero blanking.
module scan_display_ctrl #(
  parameter int DIV       = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic        Clk,
  input  logic        Aclr,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        lzb,
  output logic [3:0]  com_n,
  output logic [6:0]  seg,
  output logic        pend,
  output logic        frame_done
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  localparam logic [CW-1:0] CBLK = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   act_q, act_d;
  logic [15:0]   shd_q, shd_d;
  logic          pend_q, pend_d;
  logic          lzb_q, lzb_d;
  logic          fd_q, fd_d;

  logic          last;
  logic          bnd;

  assign last = (cnt_q == CMAX);
  assign bnd  = last && (idx_q == 2'd3);

  always_ff @(posedge Clk or posedge Aclr) begin
    if (Aclr) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      act_q  <= '0;
      shd_q  <= '0;
      pend_q <= 1'b0;
      lzb_q  <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      lzb_q  <= lzb_d;
      fd_q   <= fd_d;
    end
  end

  always_comb begin
    cnt_d  = last ? '0 : cnt_q + 1'b1;
    idx_d  = last ? idx_q + 2'd1 : idx_q;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    lzb_d  = lzb_q;
    fd_d   = 1'b0;
    // a write landing on the boundary bypasses the shadow register
    if (bnd) begin
      fd_d   = 1'b1;
      lzb_d  = lzb;
      pend_d = 1'b0;
      if (wr_en)
        act_d = wr_data;
      else if (pend_q)
        act_d = shd_q;
    end else if (wr_en) begin
      shd_d  = wr_data;
      pend_d = 1'b1;
    end
  end

  logic [3:0] digit;
  logic [6:0] dec;
  logic       z3, z2, z1;
  logic       lz_blank;

  assign digit = act_q[{idx_q, 2'b00} +: 4];
  assign z3    = (act_q[15:12] == 4'd0);
  assign z2    = z3 && (act_q[11:8] == 4'd0);
  assign z1    = z2 && (act_q[7:4] == 4'd0);

  always_comb begin
    case (digit)
      4'd0:    dec = 7'b1111110;
      4'd1:    dec = 7'b0110000;
      4'd2:    dec = 7'b1101101;
      4'd3:    dec = 7'b1111001;
      4'd4:    dec = 7'b0110011;
      4'd5:    dec = 7'b1011011;
      4'd6:    dec = 7'b1011111;
      4'd7:    dec = 7'b1110000;
      4'd8:    dec = 7'b1111111;
      4'd9:    dec = 7'b1111011;
      default: dec = 7'b0000000;
    endcase
  end

  always_comb begin
    lz_blank = 1'b0;
    if (lzb_q) begin
      case (idx_q)
        2'd3:    lz_blank = z3;
        2'd2:    lz_blank = z2;
        2'd1:    lz_blank = z1;
        default: lz_blank = 1'b0;
      endcase
    end
  end

  always_comb begin
    com_n = 4'b1111;
    seg   = 7'b0000000;
    if (cnt_q >= CBLK) begin
      com_n = ~(4'b0001 << idx_q);
      seg   = lz_blank ? 7'b0000000 : dec;
    end
  end

  assign pend       = pend_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Scoreboard bench for scan_display_ctrl: stimulus queues expected outputs
// per cycle, a negedge monitor pops and compares them.
module tb_scan_display_ctrl;

  localparam int B = 3;

  logic        Clk;
  logic        Aclr;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        lzb;
  logic [3:0]  com_n;
  logic [6:0]  seg;
  logic        pend;
  logic        frame_done;

  scan_display_ctrl #(.DIV(4), .BLANK_CYC(1)) dut (
    .Clk        (Clk),
    .Aclr       (Aclr),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .lzb        (lzb),
    .com_n      (com_n),
    .seg        (seg),
    .pend       (pend),
    .frame_done (frame_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int tcyc = 0;
  always @(posedge Clk) tcyc <= tcyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] com;
    logic [6:0] seg;
    logic       pend;
    logic       fd;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always @(negedge Clk) begin
    while (q.size() > 0 && q[0].cyc <= tcyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc < tcyc) begin
        errors++;
        $display("FAIL %s: cycle %0d never sampled (now %0d)", e.nm, e.cyc, tcyc);
      end else if ({com_n, seg, pend, frame_done} !== {e.com, e.seg, e.pend, e.fd}) begin
        errors++;
        $display("FAIL %s @%0d: got com_n=%b seg=%b pend=%b fd=%b, want com_n=%b seg=%b pend=%b fd=%b",
                 e.nm, tcyc, com_n, seg, pend, frame_done, e.com, e.seg, e.pend, e.fd);
      end
    end
  end

  task automatic push_abs(input int c, input logic [3:0] cm, input logic [6:0] s,
                          input logic p, input logic f, input string nm);
    exp_t x;
    x.cyc  = c;
    x.com  = cm;
    x.seg  = s;
    x.pend = p;
    x.fd   = f;
    x.nm   = nm;
    q.push_back(x);
  endtask

  task automatic push(input int n, input logic [3:0] cm, input logic [6:0] s,
                      input logic p, input logic f, input string nm);
    push_abs(B + n, cm, s, p, f, nm);
  endtask

  task automatic wait_neg(input int c);
    int g;
    g = 0;
    do begin
      @(negedge Clk);
      g++;
    end while (tcyc != c && g < 1000);
    if (tcyc != c) begin
      checks++;
      errors++;
      $display("FAIL wait: reached %0d, want %0d", tcyc, c);
    end
  endtask

  task automatic wr(input int n, input logic [15:0] d, input logic l);
    wait_neg(B + n);
    wr_en   = 1'b1;
    wr_data = d;
    lzb     = l;
    wait_neg(B + n + 1);
    wr_en   = 1'b0;
  endtask

  localparam logic [6:0] S0 = 7'h7E;
  localparam logic [6:0] S7 = 7'h70;
  localparam logic [6:0] S8 = 7'h7F;
  localparam logic [6:0] S9 = 7'h7B;

  initial begin
    logic [6:0] s1234 [4];
    logic [3:0] one;
    int         g;
    s1234 = '{7'h33, 7'h79, 7'h6D, 7'h30};
    one   = 4'b0001;

    Aclr    = 1'b1;
    wr_en   = 1'b0;
    wr_data = 16'h0000;
    lzb     = 1'b0;

    for (int c = 1; c <= 3; c++)
      push_abs(c, 4'hF, 7'h00, 1'b0, 1'b0, "reset");

    push(1,  4'hE, S0, 1'b0, 1'b0, "scan_prewrite");
    push(2,  4'hE, S0, 1'b1, 1'b0, "scan_pend_rise");
    push(15, 4'h7, S0, 1'b1, 1'b0, "scan_pend_bnd");
    for (int n = 16; n < 32; n++) begin
      int k;
      k = (n - 16) / 4;
      if ((n - 16) % 4 == 0)
        push(n, 4'hF, 7'h00, 1'b0, (n == 16), "scan_blank");
      else
        push(n, ~(one << k), s1234[k], 1'b0, 1'b0, "scan_on");
    end
    push(32, 4'hF, 7'h00, 1'b0, 1'b1, "frame_period");

    push(38, 4'hD, 7'h79, 1'b0, 1'b0, "dbuf_wr_cycle");
    push(39, 4'hD, 7'h79, 1'b1, 1'b0, "dbuf_pend");
    push(41, 4'hB, 7'h6D, 1'b1, 1'b0, "dbuf_d2_old");
    push(45, 4'h7, 7'h30, 1'b1, 1'b0, "dbuf_d3_old");
    push(47, 4'h7, 7'h30, 1'b1, 1'b0, "dbuf_bnd");
    push(48, 4'hF, 7'h00, 1'b0, 1'b1, "dbuf_swap");
    push(49, 4'hE, S9, 1'b0, 1'b0, "dbuf_d0_9");
    push(53, 4'hD, S9, 1'b0, 1'b0, "dbuf_d1_9");
    push(57, 4'hB, S9, 1'b0, 1'b0, "dbuf_d2_9");
    push(61, 4'h7, S9, 1'b0, 1'b0, "dbuf_d3_9");

    push(79, 4'h7, S9, 1'b0, 1'b0, "bwr_cycle");
    push(80, 4'hF, 7'h00, 1'b0, 1'b1, "bwr_nopend");
    push(81, 4'hE, S8, 1'b0, 1'b0, "bwr_d0_8");

    push(83, 4'hE, S8, 1'b1, 1'b0, "lzb_pend");
    push(85, 4'hD, S0, 1'b1, 1'b0, "lzb_not_yet");
    push(95, 4'h7, S0, 1'b1, 1'b0, "lzb_bnd");
    push(96, 4'hF, 7'h00, 1'b0, 1'b1, "lzb_frame");
    push(97, 4'hE, S0, 1'b0, 1'b0, "lzb_d0_kept");
    push(101, 4'hD, S7, 1'b1, 1'b0, "lzb_d1_7");
    push(105, 4'hB, 7'h00, 1'b1, 1'b0, "lzb_d2_blank");
    push(109, 4'h7, 7'h00, 1'b1, 1'b0, "lzb_d3_blank");
    push(112, 4'hF, 7'h00, 1'b0, 1'b1, "hex_frame");
    push(113, 4'hE, 7'h00, 1'b0, 1'b0, "hex_F");
    push(117, 4'hD, 7'h00, 1'b0, 1'b0, "hex_A");
    push(121, 4'hB, S0, 1'b0, 1'b0, "hex_d2_0");
    push(125, 4'h7, S0, 1'b0, 1'b0, "hex_d3_0");

    push(129, 4'hE, 7'h00, 1'b1, 1'b0, "mrst_pend");
    push(137, 4'hB, S0, 1'b1, 1'b0, "mrst_before");
    push(138, 4'hF, 7'h00, 1'b0, 1'b0, "mrst_blank");
    push(139, 4'hE, S0, 1'b0, 1'b0, "mrst_d0");
    push(142, 4'hF, 7'h00, 1'b0, 1'b0, "mrst_slot1_blank");
    push(143, 4'hD, S0, 1'b0, 1'b0, "mrst_d1");
    push(153, 4'h7, S0, 1'b0, 1'b0, "mrst_nopend");
    push(154, 4'hF, 7'h00, 1'b0, 1'b1, "mrst_fd");
    push(155, 4'hE, S0, 1'b0, 1'b0, "mrst_discard");

    for (int i = 1; i <= 3; i++) begin
      @(negedge Clk);
      wr_en   = ~wr_en;
      wr_data = 16'h1234;
    end
    Aclr  = 1'b0;
    wr_en = 1'b0;

    wr(1,   16'h1234, 1'b0);
    wr(38,  16'h5678, 1'b0);
    wr(40,  16'h9999, 1'b0);
    wr(79,  16'h0008, 1'b0);
    wr(82,  16'h0070, 1'b1);
    wr(100, 16'h00AF, 1'b0);
    wr(128, 16'h4321, 1'b0);

    g = 0;
    do begin
      @(posedge Clk);
      #1;
      g++;
    end while (tcyc != B + 138 && g < 1000);
    Aclr = 1'b1;
    @(negedge Clk);
    Aclr = 1'b0;

    g = 0;
    while (q.size() > 0 && g < 100) begin
      @(negedge Clk);
      g++;
    end
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d left unchecked", e.nm, e.cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
